// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM access controller.
// Optional build macro: SRAM_PARITY_EN adds one even-parity column per row.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 4;
    localparam int unsigned SRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRE    = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } sram_state_e;

    // Number of physical bitline column pairs for a given data width.
    function automatic int unsigned sram_col_w(input int unsigned data_w);
`ifdef SRAM_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response handshake between a requester and the SRAM controller.
interface sram_ctrl_if #(
    parameter int unsigned ADDR_W = sram_pkg::SRAM_ADDR_W,
    parameter int unsigned DATA_W = sram_pkg::SRAM_DATA_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sram_row_decoder.sv
// Full one-hot row decoder; all wordlines low when disabled.
module sram_row_decoder #(
    parameter int unsigned ADDR_W = sram_pkg::SRAM_ADDR_W
) (
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic                     en_i,
    output logic [(1 << ADDR_W)-1:0] wl_o
);

    // Select exactly one row when enabled.
    always_comb begin
        wl_o = '0;
        if (en_i) begin
            wl_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// Sequences single-word SRAM accesses: precharge, wordline, drive/sense, respond.
// Optional build macro: SRAM_PARITY_EN (extra even-parity column, checked on read).
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    sram_ctrl_if.slave                        bus,
    output logic [(1 << ADDR_W)-1:0]          wl,
    output logic                              bl_drv_en,
    output logic [sram_col_w(DATA_W)-1:0]     bl_out,
    output logic [sram_col_w(DATA_W)-1:0]     blb_out,
    input  logic [sram_col_w(DATA_W)-1:0]     bl_in,
    input  logic [sram_col_w(DATA_W)-1:0]     blb_in
);

    localparam int unsigned COL_W = sram_col_w(DATA_W);
    localparam int unsigned NROWS = 1 << ADDR_W;

    sram_state_e       state_q;
    logic              req_ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic [NROWS-1:0]  wl_q;
    logic              bl_drv_en_q;
    logic [COL_W-1:0]  bl_out_q;
    logic [COL_W-1:0]  blb_out_q;

    logic [NROWS-1:0]  wl_d;
    logic [COL_W-1:0]  wcol_c;
    logic [COL_W-1:0]  diff_c;
    logic              sense_err_c;

    // Wordline for the latched row, raised only for the ACCESS cycle.
    sram_row_decoder #(.ADDR_W(ADDR_W)) u_row_decoder (
        .addr_i (addr_q),
        .en_i   (state_q == PRE),
        .wl_o   (wl_d)
    );

    // Column pattern written into the row (data plus optional parity).
`ifdef SRAM_PARITY_EN
    assign wcol_c = {^wdata_q, wdata_q};
`else
    assign wcol_c = wdata_q;
`endif

    assign diff_c = bl_in ^ blb_in;

    // Sense check: every column pair must be differential; an X/Z column
    // falls through to the error branch.
    always_comb begin
        sense_err_c = 1'b1;
        if (&diff_c) begin
            sense_err_c = 1'b0;
        end
`ifdef SRAM_PARITY_EN
        if (bl_in[DATA_W] != ^bl_in[DATA_W-1:0]) begin
            sense_err_c = 1'b1;
        end
`endif
    end

    // Access FSM with registered handshake and array-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wl_q        <= '0;
            bl_drv_en_q <= 1'b0;
            bl_out_q    <= '0;
            blb_out_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            wl_q        <= wl_d;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        we_q        <= bus.req_we;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        bl_drv_en_q <= 1'b1;
                        bl_out_q    <= '1;
                        blb_out_q   <= '1;
                        state_q     <= PRE;
                    end
                end
                PRE: begin
                    bl_drv_en_q <= we_q;
                    bl_out_q    <= we_q ? wcol_c : '0;
                    blb_out_q   <= we_q ? ~wcol_c : '0;
                    state_q     <= ACCESS;
                end
                ACCESS: begin
                    bl_drv_en_q <= 1'b0;
                    bl_out_q    <= '0;
                    blb_out_q   <= '0;
                    rsp_valid_q <= 1'b1;
                    if (we_q) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end else begin
                        rsp_rdata_q <= bl_in[DATA_W-1:0];
                        rsp_err_q   <= sense_err_c;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign wl            = wl_q;
    assign bl_drv_en     = bl_drv_en_q;
    assign bl_out        = bl_out_q;
    assign blb_out       = blb_out_q;

endmodule
